// File: rtl/uart_tx_arbiter_if.sv
// Requester and UART-side signals of the shared UART transmit arbiter.
// slave is the arbiter's view; master is the view of whoever drives the requesters and the UART.
interface uart_tx_arbiter_if #(
  parameter int N   = 4,
  parameter int CHW = 2
);
  logic [8*N-1:0] ipData;
  logic [N-1:0]   ipValid;
  logic [N-1:0]   ipLast;
  logic [N-1:0]   opReady;
  logic [7:0]     opTxData;
  logic           opTxSend;
  logic           ipTxBusy;
  logic [CHW-1:0] opGrant;
  logic           opLocked;
  logic           opTimeout;

  modport slave (
    input  ipData, ipValid, ipLast, ipTxBusy,
    output opReady, opTxData, opTxSend, opGrant, opLocked, opTimeout
  );

  modport master (
    output ipData, ipValid, ipLast, ipTxBusy,
    input  opReady, opTxData, opTxSend, opGrant, opLocked, opTimeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between N byte-stream requesters, granting it per message
// in round-robin order, with a lock timeout that frees the UART from a stalled requester.
module uart_tx_arbiter #(
  parameter int N       = 4,
  parameter int CHW     = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic             ipClk,
  input  logic             ipnReset,
  uart_tx_arbiter_if.slave bus
);

  localparam int              CNTW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNTW-1:0] CNT_LAST  = CNTW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CHW-1:0]  LAST_INIT = CHW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } stateT;

  // Scan order is (after+1) .. (after+N) mod N; walking it backwards lets the
  // earliest valid channel in that order overwrite any later one.
  function automatic logic [CHW-1:0] nextWinner(input logic [N-1:0] valid,
                                                input logic [CHW-1:0] after);
    logic [CHW-1:0] winner;
    logic [N-1:0]   rot;
    int             idx;
    winner = after;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(after) + k) % N;
      rot = valid >> idx;
      if (rot[0]) winner = CHW'(idx);
    end
    return winner;
  endfunction

  stateT           state, stateNext;
  logic [7:0]      txData, txDataNext;
  logic            txSend, txSendNext;
  logic            locked, lockedNext;
  logic [CHW-1:0]  grant, grantNext;
  logic [CHW-1:0]  last, lastNext;
  logic [CNTW-1:0] toCnt, toCntNext;
  logic            toPulse, toPulseNext;

  logic            readyAll;
  logic            grantValid;
  logic            grantLast;
  logic [7:0]      grantByte;
  logic            accept;

  assign grantValid = bus.ipValid[grant];
  assign grantLast  = bus.ipLast[grant];
  assign grantByte  = bus.ipData[{grant, 3'b000} +: 8];

  // Only the locked channel may hand over a byte, and only while the UART is free.
  assign readyAll = (state == IDLE) && locked && !bus.ipTxBusy;
  assign accept   = readyAll && grantValid;

  assign bus.opReady   = readyAll ? (N'(1) << grant) : '0;
  assign bus.opTxData  = txData;
  assign bus.opTxSend  = txSend;
  assign bus.opGrant   = grant;
  assign bus.opLocked  = locked;
  assign bus.opTimeout = toPulse;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path through
    // the case can leave one unassigned and infer a latch.
    stateNext   = state;
    txDataNext  = txData;
    txSendNext  = txSend;
    lockedNext  = locked;
    grantNext   = grant;
    lastNext    = last;
    toCntNext   = toCnt;
    toPulseNext = 1'b0;

    unique case (state)
      IDLE: begin
        if (locked) begin
          if (accept) begin
            txDataNext = grantByte;
            txSendNext = 1'b1;
            stateNext  = SEND;
            toCntNext  = '0;
            if (grantLast) begin
              lockedNext = 1'b0;
              lastNext   = grant;
            end
          end else if ((TIMEOUT > 0) && !grantValid) begin
            // A byte arriving on the expiry cycle is accepted above instead.
            if (toCnt == CNT_LAST) begin
              lockedNext  = 1'b0;
              lastNext    = grant;
              toPulseNext = 1'b1;
              toCntNext   = '0;
            end else if (toCnt != '1) begin
              toCntNext = toCnt + 1'b1;
            end
          end
        end else if (!bus.ipTxBusy && (|bus.ipValid)) begin
          grantNext  = nextWinner(bus.ipValid, last);
          lockedNext = 1'b1;
        end
      end

      SEND: begin
        if (bus.ipTxBusy) begin
          txSendNext = 1'b0;
          stateNext  = WAIT;
        end
      end

      WAIT: begin
        if (!bus.ipTxBusy) stateNext = IDLE;
      end

      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge ipClk or negedge ipnReset) begin
    if (!ipnReset) begin
      state   <= IDLE;
      txData  <= '0;
      txSend  <= 1'b0;
      locked  <= 1'b0;
      grant   <= '0;
      last    <= LAST_INIT;
      toCnt   <= '0;
      toPulse <= 1'b0;
    end else begin
      // NOTE: non-blocking updates make every register read the pre-edge values
      // computed above, independent of statement order.
      state   <= stateNext;
      txData  <= txDataNext;
      txSend  <= txSendNext;
      locked  <= lockedNext;
      grant   <= grantNext;
      last    <= lastNext;
      toCnt   <= toCntNext;
      toPulse <= toPulseNext;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: queue-fed requesters, a UART busy model,
// and a message-level round-robin reference model.
module tb_uart_tx_arbiter;
  localparam int N       = 4;
  localparam int CHW     = 2;
  localparam int TIMEOUT = 8;

  logic ipClk    = 1'b0;
  logic ipnReset = 1'b0;
  always #5 ipClk = ~ipClk;

  uart_tx_arbiter_if #(.N(N), .CHW(CHW)) bus ();

  uart_tx_arbiter #(.N(N), .CHW(CHW), .TIMEOUT(TIMEOUT)) dut (
    .ipClk   (ipClk),
    .ipnReset(ipnReset),
    .bus     (bus)
  );

  int nChecks = 0;
  int nPass   = 0;
  int nFail   = 0;

  typedef logic [8:0] byteQT[$];        // {last, data}
  byteQT srcQ [N];                      // what each requester still has to offer
  byteQT mdlQ [N];                      // same traffic, as seen by the reference model
  logic [CHW+7:0] got [$];              // {grant, byte} observed at each send
  logic [CHW+7:0] expQ[$];              // {channel, byte} predicted by the model
  int mdlLast = N - 1;

  logic [N-1:0][7:0] dataArr;
  logic modelBusy  = 1'b0;
  logic busyForce  = 1'b0;
  logic uartActive = 1'b0;
  int   busyLen    = 10;
  bit   busyRand   = 1'b0;

  assign bus.ipData   = dataArr;
  assign bus.ipTxBusy = modelBusy | busyForce;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else begin
      nFail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Requesters: present the head of each queue, pop it when the DUT took it.
  initial begin
    logic [N-1:0] acc;
    bus.ipValid = '0;
    bus.ipLast  = '0;
    dataArr     = '0;
    forever begin
      @(negedge ipClk);
      #4;
      acc = bus.ipValid & bus.opReady;
      @(posedge ipClk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i] && srcQ[i].size() > 0) void'(srcQ[i].pop_front());
        if (srcQ[i].size() > 0) begin
          bus.ipValid[i] = 1'b1;
          bus.ipLast[i]  = srcQ[i][0][8];
          dataArr[i]     = srcQ[i][0][7:0];
        end else begin
          bus.ipValid[i] = 1'b0;
          bus.ipLast[i]  = 1'b0;
          dataArr[i]     = 8'($urandom);
        end
      end
    end
  end

  // UART: busy rises 2 cycles after send is seen and stays up for a while.
  initial begin
    forever begin
      @(negedge ipClk);
      if (bus.opTxSend && !uartActive) begin
        uartActive = 1'b1;
        repeat (2) @(posedge ipClk);
        #1 modelBusy = 1'b1;
        repeat (busyRand ? int'($urandom_range(1, 5)) : busyLen) @(posedge ipClk);
        #1 modelBusy = 1'b0;
        uartActive = 1'b0;
      end
    end
  end

  // Per-cycle protocol checks and capture of every byte handed to the UART.
  initial begin
    logic       prevSend = 1'b0;
    logic       prevBusy = 1'b0;
    logic       prevRstn = 1'b0;
    logic [7:0] prevData = '0;
    forever begin
      @(negedge ipClk);
      if (ipnReset && prevRstn) begin
        check("ready_onehot", 32'(bus.opReady & ~(N'(1) << bus.opGrant)), 32'(0));
        if (bus.ipTxBusy || !bus.opLocked) check("ready_blocked", 32'(bus.opReady), 32'(0));
        if (prevSend) check("send_drop", 32'(bus.opTxSend), 32'(!prevBusy));
        if (prevSend && bus.opTxSend) check("data_hold", 32'(bus.opTxData), 32'(prevData));
        if (bus.opTxSend && !prevSend) got.push_back({bus.opGrant, bus.opTxData});
      end
      prevSend = bus.opTxSend;
      prevBusy = bus.ipTxBusy;
      prevData = bus.opTxData;
      prevRstn = ipnReset;
    end
  end

  task automatic pushByte(input int ch, input logic [7:0] d, input logic l, input bit mdl);
    srcQ[ch].push_back({l, d});
    if (mdl) mdlQ[ch].push_back({l, d});
  endtask

  // Whole messages, one owner at a time, next owner searched from the previous one.
  function automatic void runModel();
    bit         found;
    int         ch;
    int         c;
    logic [8:0] e;
    do begin
      found = 1'b0;
      ch    = 0;
      for (int k = 1; k <= N; k++) begin
        c = (mdlLast + k) % N;
        if (!found && mdlQ[c].size() > 0) begin
          found = 1'b1;
          ch    = c;
        end
      end
      if (found) begin
        do begin
          e = mdlQ[ch].pop_front();
          expQ.push_back({CHW'(ch), e[7:0]});
        end while (!e[8] && mdlQ[ch].size() > 0);
        mdlLast = ch;
      end
    end while (found);
  endfunction

  function automatic logic [CHW+7:0] gotAt(input int i);
    if (i < got.size()) return got[i];
    return 'x;
  endfunction

  function automatic bit allEmpty();
    for (int i = 0; i < N; i++) if (srcQ[i].size() > 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic waitGot(input int n, input int budget, input string tag);
    int c = 0;
    while (got.size() < n && c < budget) begin
      @(negedge ipClk);
      c++;
    end
    check({tag, "_count"}, 32'(got.size() >= n), 32'(1));
  endtask

  task automatic waitQuiet(input int budget, input string tag);
    int c = 0;
    while (c < budget && !(!bus.opTxSend && !bus.ipTxBusy && !uartActive &&
                           !bus.opLocked && allEmpty())) begin
      @(negedge ipClk);
      c++;
    end
    check({tag, "_quiet"}, 32'(c < budget), 32'(1));
    repeat (2) @(negedge ipClk);
  endtask

  task automatic compareExp(input string tag);
    check({tag, "_len"}, 32'(got.size()), 32'(expQ.size()));
    for (int i = 0; i < expQ.size(); i++) check(tag, 32'(gotAt(i)), 32'(expQ[i]));
    got.delete();
    expQ.delete();
  endtask

  initial begin
    int         cnt;
    int         c;
    bit         seen;
    int         ch;
    int         len;
    int         total;

    // Reset state
    repeat (3) @(negedge ipClk);
    check("rst_send",    32'(bus.opTxSend),  32'(0));
    check("rst_data",    32'(bus.opTxData),  32'(0));
    check("rst_locked",  32'(bus.opLocked),  32'(0));
    check("rst_grant",   32'(bus.opGrant),   32'(0));
    check("rst_timeout", 32'(bus.opTimeout), 32'(0));
    check("rst_ready",   32'(bus.opReady),   32'(0));
    #2 ipnReset = 1'b1;

    // Contention after reset: ch0 and ch2, 3-byte messages each
    busyLen = 3;
    @(negedge ipClk);
    for (int b = 0; b < 3; b++) begin
      pushByte(0, 8'hA0 + 8'(b), 1'(b == 2), 1'b1);
      pushByte(2, 8'hB0 + 8'(b), 1'(b == 2), 1'b1);
    end
    runModel();
    check("contend_first_ch", 32'(expQ[0][CHW+7:8]), 32'(0));
    waitGot(6, 500, "contend");
    compareExp("contend");
    waitQuiet(200, "contend");

    // Round robin: all four channels keep offering 1-byte messages
    busyLen = 2;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) pushByte(i, 8'($urandom), 1'b1, 1'b1);
    runModel();
    waitGot(8, 600, "rr");
    compareExp("rr");
    waitQuiet(200, "rr");

    // Single requester on ch1, UART busy for 10 cycles per byte
    busyLen = 10;
    pushByte(1, 8'h41, 1'b0, 1'b1);
    pushByte(1, 8'h42, 1'b1, 1'b1);
    runModel();
    expQ.delete();
    waitGot(2, 300, "single");
    check("single_b0", 32'(gotAt(0)), 32'({2'd1, 8'h41}));
    check("single_b1", 32'(gotAt(1)), 32'({2'd1, 8'h42}));
    waitQuiet(200, "single");
    check("single_unlocked", 32'(bus.opLocked), 32'(0));
    check("single_grant",    32'(bus.opGrant),  32'(1));
    got.delete();

    // Last=1, so among ch0/ch1/ch2 the search starts at ch2
    busyLen = 2;
    pushByte(0, 8'h50, 1'b1, 1'b1);
    pushByte(1, 8'h51, 1'b1, 1'b1);
    pushByte(2, 8'h52, 1'b1, 1'b1);
    runModel();
    waitGot(3, 300, "last_ptr");
    check("last_ptr_first", 32'(gotAt(0)), 32'({2'd2, 8'h52}));
    compareExp("last_ptr");
    waitQuiet(200, "last_ptr");

    // Randomized messages with random UART busy times
    busyRand = 1'b1;
    for (int m = 0; m < 12; m++) begin
      ch  = int'($urandom_range(0, N - 1));
      len = int'($urandom_range(1, 3));
      for (int b = 0; b < len; b++) pushByte(ch, 8'($urandom), 1'(b == len - 1), 1'b1);
    end
    runModel();
    total = expQ.size();
    waitGot(total, 3000, "rand");
    compareExp("rand");
    waitQuiet(300, "rand");
    busyRand = 1'b0;

    // Busy held in IDLE while locked with a valid byte pending
    busyLen = 3;
    pushByte(0, 8'h61, 1'b0, 1'b0);
    pushByte(0, 8'h62, 1'b1, 1'b0);
    waitGot(1, 200, "hold_first");
    c = 0;
    while (!bus.opReady[0] && c < 100) begin
      @(negedge ipClk);
      c++;
    end
    check("hold_ready_seen", 32'(bus.opReady[0]), 32'(1));
    busyForce = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge ipClk);
      check("hold_ready", 32'(bus.opReady),  32'(0));
      check("hold_send",  32'(bus.opTxSend), 32'(0));
    end
    check("hold_locked", 32'(bus.opLocked), 32'(1));
    check("hold_nosend", 32'(got.size()),   32'(1));
    busyForce = 1'b0;
    waitGot(2, 200, "hold");
    check("hold_b1", 32'(gotAt(1)), 32'({2'd0, 8'h62}));
    waitQuiet(200, "hold");
    got.delete();

    // Lock timeout: ch3 stalls after a non-last byte while ch1 waits
    pushByte(3, 8'h73, 1'b0, 1'b0);
    waitGot(1, 200, "to_first");
    pushByte(1, 8'h71, 1'b1, 1'b0);
    cnt  = 0;
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge ipClk);
      if (bus.opTimeout) seen = 1'b1;
      else if (bus.opReady[3]) cnt++;
    end
    check("to_pulse",      32'(seen),         32'(1));
    check("to_idle_count", 32'(cnt),          32'(TIMEOUT));
    check("to_unlocked",   32'(bus.opLocked), 32'(0));
    @(negedge ipClk);
    check("to_pulse_width", 32'(bus.opTimeout), 32'(0));
    check("to_relock",      32'(bus.opLocked),  32'(1));
    check("to_next_grant",  32'(bus.opGrant),   32'(1));
    waitGot(2, 200, "to");
    check("to_b0", 32'(gotAt(0)), 32'({2'd3, 8'h73}));
    check("to_b1", 32'(gotAt(1)), 32'({2'd1, 8'h71}));
    waitQuiet(200, "to");
    got.delete();

    // Reset while in SEND, then ch0 wins over the leftover of ch2
    pushByte(2, 8'h81, 1'b0, 1'b0);
    pushByte(2, 8'h82, 1'b1, 1'b0);
    c = 0;
    while (!bus.opTxSend && c < 200) begin
      @(negedge ipClk);
      c++;
    end
    check("rstop_in_send", 32'(bus.opTxSend), 32'(1));
    #2 ipnReset = 1'b0;
    #1;
    check("rstop_send",   32'(bus.opTxSend), 32'(0));
    check("rstop_locked", 32'(bus.opLocked), 32'(0));
    check("rstop_grant",  32'(bus.opGrant),  32'(0));
    pushByte(0, 8'h91, 1'b1, 1'b0);
    c = 0;
    while (uartActive && c < 100) begin
      @(negedge ipClk);
      c++;
    end
    repeat (2) @(negedge ipClk);
    got.delete();
    #2 ipnReset = 1'b1;
    waitGot(2, 300, "rstop");
    check("rstop_b0", 32'(gotAt(0)), 32'({2'd0, 8'h91}));
    check("rstop_b1", 32'(gotAt(1)), 32'({2'd2, 8'h82}));
    waitQuiet(200, "rstop");

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", nPass, nChecks);
    $fatal(1, "watchdog expired");
  end

endmodule
